// File: rtl/axi_rd_arbiter_if.sv
// AXI4 read-address and read-data channel bundle.
// The master modport drives AR and RREADY. The slave modport drives ARREADY and the R payload.
interface axi_rd_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 64
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic [7:0]            arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic [3:0]            arcache;
    logic                  arvalid;
    logic                  arready;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  rvalid;
    logic                  rready;
    logic                  rlast;

    modport master (
        output araddr, arlen, arsize, arburst, arcache, arvalid, rready,
        input  arready, rdata, rvalid, rlast
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arcache, arvalid, rready,
        output arready, rdata, rvalid, rlast
    );
endinterface

// File: rtl/axi_rd_arbiter.sv
// Two-to-one AXI4 read arbiter sharing one DDR HP read port.
// Requester 0 is the display frame reader and requester 1 is the secondary reader.
// Only one read transaction is outstanding at a time.
// AR is forwarded for the granted requester. R is routed back to it until RLAST.
module axi_rd_arbiter #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 64,
    parameter bit M0_PRIORITY    = 1'b0
) (
    input  logic            clk_100Mhz,
    input  logic            rst_n,
    axi_rd_arbiter_if.slave  s0,
    axi_rd_arbiter_if.slave  s1,
    axi_rd_arbiter_if.master m,
    output logic            grant,
    output logic [1:0]      state,
    output logic            len_err
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                    state_reg;
    logic                      grant_reg;
    logic                      last_grant_reg;
    logic                      len_err_reg;
    logic [8:0]                beat_cnt_reg;
    logic [7:0]                arlen_reg;

    logic [AXI_ADDR_WIDTH-1:0] araddr_sel;
    logic [7:0]                arlen_sel;
    logic [2:0]                arsize_sel;
    logic [1:0]                arburst_sel;
    logic [3:0]                arcache_sel;
    logic                      arvalid_sel;
    logic                      rready_sel;
    logic [AXI_DATA_WIDTH-1:0] rdata_bcast;
    logic                      ar_hs;
    logic                      r_hs;

    assign grant   = grant_reg;
    assign state   = state_reg;
    assign len_err = len_err_reg;

    // Select the granted requester's AR fields and gate valid/ready by the FSM phase.
    always_comb begin
        araddr_sel  = grant_reg ? s1.araddr  : s0.araddr;
        arlen_sel   = grant_reg ? s1.arlen   : s0.arlen;
        arsize_sel  = grant_reg ? s1.arsize  : s0.arsize;
        arburst_sel = grant_reg ? s1.arburst : s0.arburst;
        arcache_sel = grant_reg ? s1.arcache : s0.arcache;
        arvalid_sel = 1'b0;
        rready_sel  = 1'b0;
        if (state_reg == ST_ADDR) begin
            arvalid_sel = grant_reg ? s1.arvalid : s0.arvalid;
        end
        if (state_reg == ST_DATA) begin
            rready_sel = grant_reg ? s1.rready : s0.rready;
        end
    end

    assign rdata_bcast = m.rdata;
    assign ar_hs       = arvalid_sel && m.arready;
    assign r_hs        = m.rvalid && rready_sel;

    // Drive both sides of the crossbar from the selections above.
    // The R path is purely combinational, so it adds no latency.
    always_comb begin
        m.araddr   = araddr_sel;
        m.arlen    = arlen_sel;
        m.arsize   = arsize_sel;
        m.arburst  = arburst_sel;
        m.arcache  = arcache_sel;
        m.arvalid  = arvalid_sel;
        m.rready   = rready_sel;
        s0.arready = 1'b0;
        s1.arready = 1'b0;
        s0.rvalid  = 1'b0;
        s1.rvalid  = 1'b0;
        s0.rlast   = 1'b0;
        s1.rlast   = 1'b0;
        s0.rdata   = rdata_bcast;
        s1.rdata   = rdata_bcast;
        if (state_reg == ST_ADDR) begin
            if (grant_reg) begin
                s1.arready = m.arready;
            end else begin
                s0.arready = m.arready;
            end
        end
        if (state_reg == ST_DATA) begin
            if (grant_reg) begin
                s1.rvalid = m.rvalid;
                s1.rlast  = m.rlast;
            end else begin
                s0.rvalid = m.rvalid;
                s0.rlast  = m.rlast;
            end
        end
    end

    // Arbitration, transaction sequencing and burst-length check.
    // last_grant resets to 1 so that requester 0 wins the first tie.
    always_ff @(posedge clk_100Mhz or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            grant_reg      <= 1'b0;
            last_grant_reg <= 1'b1;
            len_err_reg    <= 1'b0;
            beat_cnt_reg   <= 9'd0;
            arlen_reg      <= 8'd0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (s0.arvalid || s1.arvalid) begin
                        if (s0.arvalid && s1.arvalid) begin
                            grant_reg <= M0_PRIORITY ? 1'b0 : ~last_grant_reg;
                        end else begin
                            grant_reg <= s1.arvalid;
                        end
                        state_reg <= ST_ADDR;
                    end
                end
                ST_ADDR: begin
                    // The grant is frozen here even if the requester drops ARVALID.
                    if (ar_hs) begin
                        beat_cnt_reg <= 9'd0;
                        arlen_reg    <= arlen_sel;
                        state_reg    <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (r_hs) begin
                        if (m.rlast) begin
                            if (beat_cnt_reg != {1'b0, arlen_reg}) begin
                                len_err_reg <= 1'b1;
                            end
                            last_grant_reg <= grant_reg;
                            state_reg      <= ST_IDLE;
                        end else if (beat_cnt_reg == {1'b0, arlen_reg}) begin
                            // Overrun: keep routing beats until the slave finally sends RLAST.
                            len_err_reg <= 1'b1;
                        end
                        if (beat_cnt_reg != 9'h1FF) begin
                            beat_cnt_reg <= beat_cnt_reg + 9'd1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed testbench for axi_rd_arbiter.
// A round-robin instance and a fixed-priority instance receive identical stimulus.
// The sel signal chooses which instance is observed and which one the DDR responder follows.
module tb_axi_rd_arbiter;

    logic        clk;
    logic        rst_n;
    logic        sel;

    logic [31:0] req_araddr  [2];
    logic [7:0]  req_arlen   [2];
    logic        req_arvalid [2];
    logic        req_rready  [2];

    logic        m_arready;
    logic        m_rvalid;
    logic        m_rlast;
    logic [63:0] m_rdata;

    logic        o_grant;
    logic [1:0]  o_state;
    logic        o_len_err;
    logic        o_m_arvalid;
    logic [31:0] o_m_araddr;
    logic [7:0]  o_m_arlen;
    logic        o_m_rready;
    logic        o_s_arready [2];
    logic        o_s_rvalid  [2];
    logic        o_s_rlast   [2];
    logic [63:0] o_s_rdata   [2];

    int          n_checks;
    int          n_fail;

    int          obs_lat;
    int          obs_grant;
    int          obs_beats;
    int          obs_seq_err;
    int          obs_cross;
    int          obs_rr_mis;
    int          obs_ar_err;
    int          obs_timeout;
    logic [31:0] obs_araddr;
    logic [7:0]  obs_arlen;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) s0_if ();
        axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) s1_if ();
        axi_rd_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(64)) m_if ();
        logic       grant_w;
        logic [1:0] state_w;
        logic       len_err_w;

        axi_rd_arbiter #(
            .AXI_ADDR_WIDTH(32),
            .AXI_DATA_WIDTH(64),
            .M0_PRIORITY(gi == 1)
        ) dut (
            .clk_100Mhz(clk),
            .rst_n(rst_n),
            .s0(s0_if),
            .s1(s1_if),
            .m(m_if),
            .grant(grant_w),
            .state(state_w),
            .len_err(len_err_w)
        );

        assign s0_if.araddr  = req_araddr[0];
        assign s0_if.arlen   = req_arlen[0];
        assign s0_if.arsize  = 3'd3;
        assign s0_if.arburst = 2'b01;
        assign s0_if.arcache = 4'h3;
        assign s0_if.arvalid = req_arvalid[0];
        assign s0_if.rready  = req_rready[0];
        assign s1_if.araddr  = req_araddr[1];
        assign s1_if.arlen   = req_arlen[1];
        assign s1_if.arsize  = 3'd3;
        assign s1_if.arburst = 2'b01;
        assign s1_if.arcache = 4'h3;
        assign s1_if.arvalid = req_arvalid[1];
        assign s1_if.rready  = req_rready[1];
        assign m_if.arready  = m_arready;
        assign m_if.rvalid   = m_rvalid;
        assign m_if.rlast    = m_rlast;
        assign m_if.rdata    = m_rdata;
    end

    assign o_grant        = sel ? g_dut[1].grant_w        : g_dut[0].grant_w;
    assign o_state        = sel ? g_dut[1].state_w        : g_dut[0].state_w;
    assign o_len_err      = sel ? g_dut[1].len_err_w      : g_dut[0].len_err_w;
    assign o_m_arvalid    = sel ? g_dut[1].m_if.arvalid   : g_dut[0].m_if.arvalid;
    assign o_m_araddr     = sel ? g_dut[1].m_if.araddr    : g_dut[0].m_if.araddr;
    assign o_m_arlen      = sel ? g_dut[1].m_if.arlen     : g_dut[0].m_if.arlen;
    assign o_m_rready     = sel ? g_dut[1].m_if.rready    : g_dut[0].m_if.rready;
    assign o_s_arready[0] = sel ? g_dut[1].s0_if.arready  : g_dut[0].s0_if.arready;
    assign o_s_arready[1] = sel ? g_dut[1].s1_if.arready  : g_dut[0].s1_if.arready;
    assign o_s_rvalid[0]  = sel ? g_dut[1].s0_if.rvalid   : g_dut[0].s0_if.rvalid;
    assign o_s_rvalid[1]  = sel ? g_dut[1].s1_if.rvalid   : g_dut[0].s1_if.rvalid;
    assign o_s_rlast[0]   = sel ? g_dut[1].s0_if.rlast    : g_dut[0].s0_if.rlast;
    assign o_s_rlast[1]   = sel ? g_dut[1].s1_if.rlast    : g_dut[0].s1_if.rlast;
    assign o_s_rdata[0]   = sel ? g_dut[1].s0_if.rdata    : g_dut[0].s0_if.rdata;
    assign o_s_rdata[1]   = sel ? g_dut[1].s1_if.rdata    : g_dut[0].s1_if.rdata;

    // Pulse reset for one cycle with all inputs idle. Returns at negedge + 1.
    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            req_arvalid[i] = 1'b0;
            req_rready[i]  = 1'b0;
        end
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rdata   = 64'd0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    // DDR responder for one transaction granted to requester g.
    // Records observations in obs_*. The calling test compares them.
    task automatic serve(input int g, input int nbeats, input int ar_wait,
                         input bit toggle, input bit drop_req);
        int cyc;
        int idx;
        int o;
        bit phase;
        o           = 1 - g;
        obs_lat     = 0;
        obs_grant   = -1;
        obs_beats   = 0;
        obs_seq_err = 0;
        obs_cross   = 0;
        obs_rr_mis  = 0;
        obs_ar_err  = 0;
        obs_timeout = 0;
        obs_araddr  = 32'd0;
        obs_arlen   = 8'd0;
        cyc = 0;
        while (o_m_arvalid !== 1'b1) begin
            if (cyc >= 50) begin
                obs_timeout = 1;
                return;
            end
            @(negedge clk);
            #1;
            cyc++;
        end
        obs_lat    = cyc;
        obs_grant  = int'(o_grant);
        obs_araddr = o_m_araddr;
        obs_arlen  = o_m_arlen;
        // Hold ARREADY low while spurious RVALID shows up. That RVALID must be ignored in ADDR.
        for (int k = 0; k < ar_wait; k++) begin
            m_rvalid = 1'b1;
            #1;
            if (o_s_arready[g] !== 1'b0 || o_m_arvalid !== 1'b1 ||
                o_m_rready !== 1'b0 || o_s_rvalid[g] !== 1'b0) obs_ar_err++;
            @(negedge clk);
            #1;
        end
        m_rvalid  = 1'b0;
        m_arready = 1'b1;
        #1;
        if (o_s_arready[g] !== 1'b1 || o_s_arready[o] !== 1'b0) obs_ar_err++;
        @(negedge clk);
        m_arready = 1'b0;
        if (drop_req) req_arvalid[g] = 1'b0;
        idx   = 0;
        cyc   = 0;
        phase = 1'b0;
        while (idx < nbeats) begin
            if (cyc >= 400) begin
                obs_timeout = 1;
                break;
            end
            m_rvalid = 1'b1;
            m_rdata  = 64'hD0D0_0000_0000_0000 + (64'(g) << 32) + 64'(idx);
            m_rlast  = (idx == nbeats - 1);
            req_rready[g] = toggle ? phase : 1'b1;
            phase = ~phase;
            #1;
            if (o_m_rready !== req_rready[g]) obs_rr_mis++;
            if (o_s_rvalid[o] !== 1'b0 || o_s_rlast[o] !== 1'b0) obs_cross++;
            if (o_s_rvalid[g] !== 1'b1) begin
                obs_seq_err++;
            end else if (req_rready[g]) begin
                if (o_s_rdata[g] !== m_rdata || o_s_rlast[g] !== m_rlast) obs_seq_err++;
                obs_beats++;
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        m_rvalid      = 1'b0;
        m_rlast       = 1'b0;
        req_rready[g] = 1'b0;
        #1;
        $display("txn: requester %0d addr %08h arlen %0d beats %0d latency %0d",
                 obs_grant, obs_araddr, obs_arlen, obs_beats, obs_lat);
    endtask

    task automatic test_reset();
        sel            = 1'b0;
        req_arvalid[0] = 1'b1;
        m_arready      = 1'b1;
        m_rvalid       = 1'b1;
        #1;
        n_checks++;
        if (o_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", o_state); end
        n_checks++;
        if (o_grant !== 1'b0) begin n_fail++; $display("FAIL reset_grant: got %0b want 0", o_grant); end
        n_checks++;
        if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL reset_len_err: got %0b want 0", o_len_err); end
        n_checks++;
        if (o_m_arvalid !== 1'b0 || o_s_arready[0] !== 1'b0 || o_m_rready !== 1'b0 || o_s_rvalid[0] !== 1'b0)
        begin
            n_fail++;
            $display("FAIL reset_handshakes: arvalid %0b arready %0b rready %0b rvalid %0b want all 0",
                     o_m_arvalid, o_s_arready[0], o_m_rready, o_s_rvalid[0]);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (o_state !== 2'd0) begin n_fail++; $display("FAIL reset_hold_state: got %0d want 0", o_state); end
    endtask

    task automatic test_single();
        apply_reset();
        sel            = 1'b0;
        req_araddr[0]  = 32'h0100_0000;
        req_arlen[0]   = 8'd63;
        req_arvalid[0] = 1'b1;
        serve(0, 64, 0, 1'b0, 1'b1);
        n_checks++;
        if (obs_timeout != 0 || obs_lat != 1) begin n_fail++; $display("FAIL single_latency: got %0d timeout %0d want 1", obs_lat, obs_timeout); end
        n_checks++;
        if (obs_grant != 0) begin n_fail++; $display("FAIL single_grant: got %0d want 0", obs_grant); end
        n_checks++;
        if (obs_araddr !== 32'h0100_0000 || obs_arlen !== 8'd63) begin n_fail++; $display("FAIL single_ar: got %08h/%0d want 01000000/63", obs_araddr, obs_arlen); end
        n_checks++;
        if (obs_beats != 64 || obs_seq_err != 0) begin n_fail++; $display("FAIL single_beats: got %0d (errs %0d) want 64 (0)", obs_beats, obs_seq_err); end
        n_checks++;
        if (obs_cross != 0) begin n_fail++; $display("FAIL single_s1_rvalid: got %0d cycles want 0", obs_cross); end
        n_checks++;
        if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL single_len_err: got %0b want 0", o_len_err); end
        n_checks++;
        if (o_state !== 2'd0) begin n_fail++; $display("FAIL single_state: got %0d want 0", o_state); end
    endtask

    task automatic test_round_robin();
        int exp_g;
        apply_reset();
        sel            = 1'b0;
        req_araddr[0]  = 32'h1000_0000;
        req_araddr[1]  = 32'h2000_0000;
        req_arlen[0]   = 8'd3;
        req_arlen[1]   = 8'd3;
        req_arvalid[0] = 1'b1;
        req_arvalid[1] = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_g = t % 2;
            serve(exp_g, 4, 0, 1'b0, 1'b0);
            n_checks++;
            if (obs_grant != exp_g) begin n_fail++; $display("FAIL rr_grant[%0d]: got %0d want %0d", t, obs_grant, exp_g); end
            n_checks++;
            if (obs_lat != 1 || obs_timeout != 0) begin n_fail++; $display("FAIL rr_gap[%0d]: got %0d want 1", t, obs_lat); end
            n_checks++;
            if (obs_araddr !== (exp_g == 0 ? 32'h1000_0000 : 32'h2000_0000)) begin n_fail++; $display("FAIL rr_addr[%0d]: got %08h", t, obs_araddr); end
            n_checks++;
            if (obs_beats != 4 || obs_seq_err != 0 || obs_cross != 0) begin n_fail++; $display("FAIL rr_route[%0d]: got beats %0d errs %0d cross %0d want 4/0/0", t, obs_beats, obs_seq_err, obs_cross); end
        end
        req_arvalid[0] = 1'b0;
        req_arvalid[1] = 1'b0;
    endtask

    task automatic test_backpressure();
        sel            = 1'b0;
        req_araddr[0]  = 32'h0300_0000;
        req_arlen[0]   = 8'd7;
        req_arvalid[0] = 1'b1;
        serve(0, 8, 5, 1'b1, 1'b1);
        n_checks++;
        if (obs_grant != 0 || obs_timeout != 0) begin n_fail++; $display("FAIL bp_grant: got %0d want 0", obs_grant); end
        n_checks++;
        if (obs_ar_err != 0) begin n_fail++; $display("FAIL bp_ar_stall: got %0d bad cycles want 0", obs_ar_err); end
        n_checks++;
        if (obs_beats != 8 || obs_seq_err != 0) begin n_fail++; $display("FAIL bp_beats: got %0d (errs %0d) want 8 (0)", obs_beats, obs_seq_err); end
        n_checks++;
        if (obs_rr_mis != 0) begin n_fail++; $display("FAIL bp_rready_mirror: got %0d bad cycles want 0", obs_rr_mis); end
        n_checks++;
        if (o_len_err !== 1'b0 || o_state !== 2'd0) begin n_fail++; $display("FAIL bp_end: got len_err %0b state %0d want 0/0", o_len_err, o_state); end
    endtask

    task automatic test_priority();
        apply_reset();
        sel            = 1'b1;
        req_araddr[0]  = 32'h1100_0000;
        req_araddr[1]  = 32'h2200_0000;
        req_arlen[0]   = 8'd1;
        req_arlen[1]   = 8'd1;
        req_arvalid[0] = 1'b1;
        req_arvalid[1] = 1'b1;
        for (int t = 0; t < 3; t++) begin
            serve(0, 2, 0, 1'b0, 1'b0);
            n_checks++;
            if (obs_grant != 0 || obs_beats != 2) begin n_fail++; $display("FAIL prio_grant[%0d]: got %0d beats %0d want 0/2", t, obs_grant, obs_beats); end
        end
        req_arvalid[0] = 1'b0;
        serve(1, 2, 0, 1'b0, 1'b1);
        n_checks++;
        if (obs_grant != 1 || obs_beats != 2 || obs_cross != 0) begin n_fail++; $display("FAIL prio_s1_served: got %0d beats %0d want 1/2", obs_grant, obs_beats); end
        sel = 1'b0;
    endtask

    task automatic test_len_error();
        apply_reset();
        sel            = 1'b0;
        req_araddr[0]  = 32'h0500_0000;
        req_arlen[0]   = 8'd63;
        req_arvalid[0] = 1'b1;
        serve(0, 32, 0, 1'b0, 1'b1);
        n_checks++;
        if (obs_beats != 32 || o_state !== 2'd0) begin n_fail++; $display("FAIL lenerr_end: got beats %0d state %0d want 32/0", obs_beats, o_state); end
        n_checks++;
        if (o_len_err !== 1'b1) begin n_fail++; $display("FAIL lenerr_short: got %0b want 1", o_len_err); end
        req_arlen[0]   = 8'd3;
        req_arvalid[0] = 1'b1;
        serve(0, 4, 0, 1'b0, 1'b1);
        n_checks++;
        if (o_len_err !== 1'b1 || obs_beats != 4) begin n_fail++; $display("FAIL lenerr_sticky: got %0b beats %0d want 1/4", o_len_err, obs_beats); end
        apply_reset();
        n_checks++;
        if (o_len_err !== 1'b0) begin n_fail++; $display("FAIL lenerr_reset_clear: got %0b want 0", o_len_err); end
        req_arlen[0]   = 8'd3;
        req_arvalid[0] = 1'b1;
        serve(0, 6, 0, 1'b0, 1'b1);
        n_checks++;
        if (obs_beats != 6 || obs_seq_err != 0 || o_state !== 2'd0) begin n_fail++; $display("FAIL overrun_route: got beats %0d errs %0d state %0d want 6/0/0", obs_beats, obs_seq_err, o_state); end
        n_checks++;
        if (o_len_err !== 1'b1) begin n_fail++; $display("FAIL overrun_len_err: got %0b want 1", o_len_err); end
    endtask

    task automatic test_reset_mid_burst();
        apply_reset();
        sel            = 1'b0;
        req_araddr[0]  = 32'h0400_0000;
        req_arlen[0]   = 8'd0;
        req_arvalid[0] = 1'b1;
        serve(0, 1, 0, 1'b0, 1'b1);
        req_arlen[0]   = 8'd63;
        req_arvalid[0] = 1'b1;
        @(negedge clk);
        #1;
        m_arready = 1'b1;
        @(negedge clk);
        m_arready      = 1'b0;
        req_arvalid[0] = 1'b0;
        req_rready[0]  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            m_rvalid = 1'b1;
            m_rlast  = 1'b0;
            m_rdata  = 64'(i);
            @(negedge clk);
        end
        #1;
        n_checks++;
        if (o_state !== 2'd2) begin n_fail++; $display("FAIL midrst_pre_state: got %0d want 2", o_state); end
        m_arready      = 1'b1;
        req_arvalid[0] = 1'b1;
        req_arvalid[1] = 1'b1;
        rst_n          = 1'b0;
        #1;
        n_checks++;
        if (o_state !== 2'd0 || o_grant !== 1'b0) begin n_fail++; $display("FAIL midrst_state: got state %0d grant %0b want 0/0", o_state, o_grant); end
        n_checks++;
        if (o_m_rready !== 1'b0 || o_s_rvalid[0] !== 1'b0 || o_m_arvalid !== 1'b0 || o_s_arready[0] !== 1'b0)
        begin
            n_fail++;
            $display("FAIL midrst_handshakes: rready %0b rvalid %0b arvalid %0b arready %0b want all 0",
                     o_m_rready, o_s_rvalid[0], o_m_arvalid, o_s_arready[0]);
        end
        @(negedge clk);
        rst_n     = 1'b1;
        m_rvalid  = 1'b0;
        m_arready = 1'b0;
        @(negedge clk);
        #1;
        n_checks++;
        if (o_m_arvalid !== 1'b1 || o_grant !== 1'b0 || o_m_araddr !== 32'h0400_0000) begin
            n_fail++;
            $display("FAIL midrst_first_tie: got arvalid %0b grant %0b addr %08h want 1/0/04000000",
                     o_m_arvalid, o_grant, o_m_araddr);
        end
        apply_reset();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        sel      = 1'b0;
        rst_n    = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_araddr[i]  = 32'd0;
            req_arlen[i]   = 8'd0;
            req_arvalid[i] = 1'b0;
            req_rready[i]  = 1'b0;
        end
        m_arready = 1'b0;
        m_rvalid  = 1'b0;
        m_rlast   = 1'b0;
        m_rdata   = 64'd0;
        #2;
        rst_n = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_priority();
        test_len_error();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
